pc_sequencer: RTL and testbench

- Multi-cycle fetch/sequence controller that owns the architectural PC and drives the next-PC selection for the MIPS core.
- Fetches one instruction at a time over a req/ack instruction-memory handshake and presents it to decode.
- Waits for the execute stage to report completion, then applies the sequential, branch, jump or register-jump next PC.
- Flags misaligned targets and fetch timeouts.

---
 rtl/pc_sequencer_pkg.sv | 37 +++
 rtl/pc_sequencer_if.sv | 48 ++++
 rtl/pc_sequencer_npc_calc.sv | 37 +++
 rtl/pc_sequencer.sv | 171 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer_pkg
//  Purpose  : Shared encodings for the PC sequencer and the instruction
//             decoder: next-PC select codes, sequencer states, fault codes,
//             and the branch-offset helper.
//  Revision : 1.0  initial release
// ============================================================================
package pc_sequencer_pkg;

    // Next-PC select encodings, shared with the decoder
    localparam logic [1:0] NPC_PC4    = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JMP    = 2'b10;
    localparam logic [1:0] NPC_JR     = 2'b11;

    // Sticky fault codes
    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        EXEC  = 3'd3,
        HALT  = 3'd4
    } state_e;

    // Word offset -> sign-extended byte offset
    function automatic logic [31:0] branch_byte_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer_if
//  Purpose  : Bundles the instruction-memory handshake, the decode handoff
//             and the execute-completion / redirect inputs of the sequencer.
//             master = sequencer side, slave = memory/decode/execute side.
//  Revision : 1.0  initial release
// ============================================================================
interface pc_sequencer_if;

    // Instruction memory
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    // Decode handoff
    logic        ir_valid;
    logic [31:0] ir;
    logic        ir_ready;

    // Execute completion and redirect information
    logic        ex_done;
    logic [1:0]  npc_sel;
    logic        br_taken;
    logic [15:0] br_imm;
    logic [25:0] j_addr;
    logic [31:0] jr_target;

    // Architectural state visible to the core
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [1:0]  fault;

    modport master (
        output imem_req, imem_addr, ir_valid, ir, pc, pc4, fault,
        input  imem_ack, imem_rdata, ir_ready, ex_done, npc_sel,
               br_taken, br_imm, j_addr, jr_target
    );

    modport slave (
        input  imem_req, imem_addr, ir_valid, ir, pc, pc4, fault,
        output imem_ack, imem_rdata, ir_ready, ex_done, npc_sel,
               br_taken, br_imm, j_addr, jr_target
    );

endinterface
`default_nettype wire

// File: rtl/pc_sequencer_npc_calc.sv
`default_nettype none
// ============================================================================
//  Module   : npc_calc
//  Purpose  : Combinational next-PC target selection (sequential, branch,
//             jump, register jump) with misalignment detection on JR.
//  Revision : 1.0  initial release
// ============================================================================
module npc_calc
    import pc_sequencer_pkg::*;
(
    input  wire logic [31:0] pc4,
    input  wire logic [1:0]  npc_sel,
    input  wire logic        br_taken,
    input  wire logic [15:0] br_imm,
    input  wire logic [25:0] j_addr,
    input  wire logic [31:0] jr_target,
    output logic      [31:0] target,
    output logic             misaligned
);

    // Target select; all arithmetic wraps at 32 bits
    always_comb begin
        target = pc4;
        case (npc_sel)
            NPC_PC4:    target = pc4;
            NPC_BRANCH: target = br_taken ? (pc4 + branch_byte_offset(br_imm)) : pc4;
            // Region bits come from the current pc4, never a stale target
            NPC_JMP:    target = {pc4[31:28], j_addr, 2'b00};
            NPC_JR:     target = jr_target;
            default:    target = pc4;
        endcase
        // Only a register target can carry low address bits
        misaligned = (npc_sel == NPC_JR) && (target[1:0] != 2'b00);
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer
//  Purpose  : Multi-cycle fetch/sequence controller owning the architectural
//             PC. Fetches one instruction at a time, hands it to decode,
//             waits for execute completion, then applies the next PC.
//             Flags misaligned JR targets and fetch timeouts (sticky, HALT).
//  Options  : BRANCH_DELAY_SLOT_EN - when defined, redirects are deferred by
//             one instruction (MIPS delay slot) through a pending register.
//  Revision : 1.0  initial release
// ============================================================================
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    pc_sequencer_if.master bus
);

    localparam logic [7:0] TIMEOUT_LIMIT = ACK_TIMEOUT[7:0];

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [1:0]  fault_q, fault_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [31:0] pc4;
    logic [31:0] target;
    logic        misaligned;
    logic [7:0]  cnt_inc;

`ifdef BRANCH_DELAY_SLOT_EN
    logic        pend_vld_q, pend_vld_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic        redirect;
`endif

    assign pc4     = pc_q + 32'd4;
    assign cnt_inc = cnt_q + 8'd1;

    npc_calc u_npc_calc (
        .pc4        (pc4),
        .npc_sel    (bus.npc_sel),
        .br_taken   (bus.br_taken),
        .br_imm     (bus.br_imm),
        .j_addr     (bus.j_addr),
        .jr_target  (bus.jr_target),
        .target     (target),
        .misaligned (misaligned)
    );

`ifdef BRANCH_DELAY_SLOT_EN
    // Any select that leaves the sequential path goes through the delay slot
    assign redirect = (bus.npc_sel == NPC_JMP) || (bus.npc_sel == NPC_JR) ||
                      ((bus.npc_sel == NPC_BRANCH) && bus.br_taken);
`endif

    // State register and architectural state, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= 32'h0000_0000;
            fault_q    <= FAULT_NONE;
            cnt_q      <= 8'd0;
`ifdef BRANCH_DELAY_SLOT_EN
            pend_vld_q <= 1'b0;
            pend_tgt_q <= 32'h0000_0000;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            fault_q    <= fault_d;
            cnt_q      <= cnt_d;
`ifdef BRANCH_DELAY_SLOT_EN
            pend_vld_q <= pend_vld_d;
            pend_tgt_q <= pend_tgt_d;
`endif
        end
    end

    // Next-state, fetch timeout and next-PC application
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        fault_d    = fault_q;
        cnt_d      = cnt_q;
`ifdef BRANCH_DELAY_SLOT_EN
        pend_vld_d = pend_vld_q;
        pend_tgt_d = pend_tgt_q;
`endif
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                // Ack is checked first so it wins over a coincident expiry
                if (bus.imem_ack) begin
                    ir_d    = bus.imem_rdata;
                    cnt_d   = 8'd0;
                    state_d = ISSUE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TIMEOUT_LIMIT) begin
                        fault_d = FAULT_TIMEOUT;
                        state_d = HALT;
                    end
                end
            end
            ISSUE: begin
                if (bus.ir_ready) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (bus.ex_done) begin
`ifdef BRANCH_DELAY_SLOT_EN
                    if (pend_vld_q) begin
                        // Delay-slot instruction: its own select is ignored
                        pc_d       = pend_tgt_q;
                        pend_vld_d = 1'b0;
                        state_d    = FETCH;
                    end else if (misaligned) begin
                        fault_d = FAULT_MISALIGN;
                        state_d = HALT;
                    end else if (redirect) begin
                        pc_d       = pc4;
                        pend_vld_d = 1'b1;
                        pend_tgt_d = target;
                        state_d    = FETCH;
                    end else begin
                        pc_d    = pc4;
                        state_d = FETCH;
                    end
`else
                    if (misaligned) begin
                        fault_d = FAULT_MISALIGN;
                        state_d = HALT;
                    end else begin
                        pc_d    = target;
                        state_d = FETCH;
                    end
`endif
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode directly from state and registers
    assign bus.imem_req  = (state_q == FETCH);
    assign bus.imem_addr = pc_q;
    assign bus.ir_valid  = (state_q == ISSUE);
    assign bus.ir        = ir_q;
    assign bus.pc        = pc_q;
    assign bus.pc4       = pc4;
    assign bus.fault     = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_sequencer
//  Purpose  : Self-checking bench for pc_sequencer: a table of instructions
//             with hand-computed next PCs, plus directed sequences for the
//             misaligned JR, async reset, ISSUE stall and fetch timeout.
//             Builds with or without BRANCH_DELAY_SLOT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_PC    (32'h0000_0000),
        .ACK_TIMEOUT (16)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        logic        taken;
        logic [15:0] imm;
        logic [25:0] jaddr;
        logic [31:0] jr;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] npc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [1:0] sel, input logic taken,
                                input logic [15:0] imm, input logic [25:0] jaddr,
                                input logic [31:0] jr, input logic [31:0] pc,
                                input logic [31:0] npc);
        vec_t v;
        v.sel   = sel;
        v.taken = taken;
        v.imm   = imm;
        v.jaddr = jaddr;
        v.jr    = jr;
        v.instr = 32'hA500_0000 ^ pc;
        v.pc    = pc;
        v.npc   = npc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'hDEAD_BEEF;
        bus.ir_ready   = 1'b0;
        bus.ex_done    = 1'b0;
        bus.npc_sel    = NPC_PC4;
        bus.br_taken   = 1'b0;
        bus.br_imm     = 16'h0000;
        bus.j_addr     = 26'h0;
        bus.jr_target  = 32'h0;
    endtask

    // Assert reset away from a clock edge and check outputs before any edge
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, ".pc"},       bus.pc,                32'h0);
        chk({tag, ".ir"},       bus.ir,                32'h0);
        chk({tag, ".fault"},    32'(bus.fault),        32'h0);
        chk({tag, ".imem_req"}, 32'(bus.imem_req),     32'h0);
        chk({tag, ".ir_valid"}, 32'(bus.ir_valid),     32'h0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);  // IDLE -> FETCH
    endtask

    // One instruction at minimum latency; entered at a negedge in FETCH
    task automatic do_instr(input vec_t v, input string tag);
        chk({tag, ".req"},  32'(bus.imem_req), 32'h1);
        chk({tag, ".addr"}, bus.imem_addr,     v.pc);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = v.instr;
        @(negedge clk);
        // ISSUE; stray ack/ex_done here must be ignored
        chk({tag, ".ir_valid"}, 32'(bus.ir_valid), 32'h1);
        chk({tag, ".req_iss"},  32'(bus.imem_req), 32'h0);
        chk({tag, ".ir"},       bus.ir,            v.instr);
        bus.imem_rdata = ~v.instr;
        bus.ex_done    = 1'b1;
        bus.ir_ready   = 1'b1;
        @(negedge clk);
        // EXEC
        chk({tag, ".req_exe"}, 32'(bus.imem_req), 32'h0);
        chk({tag, ".vld_exe"}, 32'(bus.ir_valid), 32'h0);
        chk({tag, ".ir_hold"}, bus.ir,            v.instr);
        chk({tag, ".pc_exe"},  bus.pc,            v.pc);
        bus.ex_done   = 1'b1;
        bus.npc_sel   = v.sel;
        bus.br_taken  = v.taken;
        bus.br_imm    = v.imm;
        bus.j_addr    = v.jaddr;
        bus.jr_target = v.jr;
        @(negedge clk);
        idle_inputs();
        chk({tag, ".npc"}, bus.pc, v.npc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc_end;
        logic [31:0] ir_snap;
        vec_t        v;

        n_cmp = 0;
        n_bad = 0;
        idle_inputs();
        rst_n = 1'b0;

`ifdef BRANCH_DELAY_SLOT_EN
        tbl.push_back(mk(NPC_JR,     1'b0, 16'h0000, 26'h0,  32'h40, 32'h00, 32'h04));
        tbl.push_back(mk(NPC_PC4,    1'b0, 16'h0000, 26'h0,  32'h0,  32'h04, 32'h40));
        tbl.push_back(mk(NPC_JMP,    1'b0, 16'h0000, 26'h20, 32'h0,  32'h40, 32'h44));
        tbl.push_back(mk(NPC_BRANCH, 1'b1, 16'hFFFC, 26'h0,  32'h0,  32'h44, 32'h80));
        tbl.push_back(mk(NPC_PC4,    1'b0, 16'h0000, 26'h0,  32'h0,  32'h80, 32'h84));
        tbl.push_back(mk(NPC_BRANCH, 1'b0, 16'h0004, 26'h0,  32'h0,  32'h84, 32'h88));
        tbl.push_back(mk(NPC_BRANCH, 1'b1, 16'h0004, 26'h0,  32'h0,  32'h88, 32'h8C));
        tbl.push_back(mk(NPC_JMP,    1'b0, 16'h0000, 26'h0,  32'h0,  32'h8C, 32'h9C));
        tbl.push_back(mk(NPC_PC4,    1'b0, 16'h0000, 26'h0,  32'h0,  32'h9C, 32'hA0));
`else
        tbl.push_back(mk(NPC_PC4,    1'b0, 16'h0000, 26'h0,       32'h0,         32'h0000_0000, 32'h0000_0004));
        tbl.push_back(mk(NPC_PC4,    1'b0, 16'h0000, 26'h0,       32'h0,         32'h0000_0004, 32'h0000_0008));
        tbl.push_back(mk(NPC_JR,     1'b0, 16'h0000, 26'h0,       32'h100,       32'h0000_0008, 32'h0000_0100));
        tbl.push_back(mk(NPC_BRANCH, 1'b1, 16'hFFFC, 26'h0,       32'h0,         32'h0000_0100, 32'h0000_00F4));
        tbl.push_back(mk(NPC_JR,     1'b0, 16'h0000, 26'h0,       32'h100,       32'h0000_00F4, 32'h0000_0100));
        tbl.push_back(mk(NPC_BRANCH, 1'b0, 16'hFFFC, 26'h0,       32'h0,         32'h0000_0100, 32'h0000_0104));
        tbl.push_back(mk(NPC_BRANCH, 1'b1, 16'h0003, 26'h0,       32'h0,         32'h0000_0104, 32'h0000_0114));
        tbl.push_back(mk(NPC_JR,     1'b0, 16'h0000, 26'h0,       32'h9000_000C, 32'h0000_0114, 32'h9000_000C));
        tbl.push_back(mk(NPC_PC4,    1'b0, 16'h0000, 26'h0,       32'h0,         32'h9000_000C, 32'h9000_0010));
        tbl.push_back(mk(NPC_JMP,    1'b0, 16'h0000, 26'h40,      32'h0,         32'h9000_0010, 32'h9000_0100));
        tbl.push_back(mk(NPC_JR,     1'b0, 16'h0000, 26'h0,       32'hFFFF_FFFC, 32'h9000_0100, 32'hFFFF_FFFC));
        tbl.push_back(mk(NPC_PC4,    1'b0, 16'h0000, 26'h0,       32'h0,         32'hFFFF_FFFC, 32'h0000_0000));
        tbl.push_back(mk(NPC_JMP,    1'b0, 16'h0000, 26'h3FFFFFF, 32'h0,         32'h0000_0000, 32'h0FFF_FFFC));
        tbl.push_back(mk(NPC_JMP,    1'b0, 16'h0000, 26'h10,      32'h0,         32'h0FFF_FFFC, 32'h1000_0040));
`endif

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.pc",       bus.pc,            32'h0);
        chk("rst.pc4",      bus.pc4,           32'h4);
        chk("rst.ir",       bus.ir,            32'h0);
        chk("rst.fault",    32'(bus.fault),    32'h0);
        chk("rst.imem_req", 32'(bus.imem_req), 32'h0);
        chk("rst.ir_valid", 32'(bus.ir_valid), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table of instructions back to back
        foreach (tbl[i]) begin
            do_instr(tbl[i], $sformatf("vec%0d", i));
        end
        pc_end = tbl[tbl.size() - 1].npc;

        // Misaligned JR: fault, HALT, pc frozen
        v = mk(NPC_JR, 1'b0, 16'h0, 26'h0, 32'h202, pc_end, pc_end);
        do_instr(v, "misalign");
        chk("misalign.fault", 32'(bus.fault),    32'(FAULT_MISALIGN));
        chk("misalign.req",   32'(bus.imem_req), 32'h0);
        bus.imem_ack = 1'b1;
        bus.ir_ready = 1'b1;
        bus.ex_done  = 1'b1;
        repeat (3) @(negedge clk);
        chk("halt.req",   32'(bus.imem_req), 32'h0);
        chk("halt.vld",   32'(bus.ir_valid), 32'h0);
        chk("halt.pc",    bus.pc,            pc_end);
        chk("halt.fault", 32'(bus.fault),    32'(FAULT_MISALIGN));

        // Reset out of HALT
        async_reset("rst_halt");
        do_instr(mk(NPC_PC4, 1'b0, 16'h0, 26'h0, 32'h0, 32'h0, 32'h4), "post_rst");

        // ISSUE stall: ir_valid held, ir stable
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h1234_5678;
        @(negedge clk);
        idle_inputs();
        ir_snap = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d.vld", i), 32'(bus.ir_valid), 32'h1);
            chk($sformatf("stall%0d.ir", i),  bus.ir,            ir_snap);
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = 32'hFFFF_0000;
            @(negedge clk);
            idle_inputs();
        end
        bus.ir_ready = 1'b1;
        @(negedge clk);
        bus.ir_ready = 1'b0;
        chk("exec.vld", 32'(bus.ir_valid), 32'h0);
        chk("exec.pc",  bus.pc,            32'h4);

        // Reset mid-EXEC clears everything before the next edge
        async_reset("rst_exec");
        chk("rst_exec.addr", bus.imem_addr, 32'h0);

        // Fetch timeout: 16 cycles without ack
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("to%0d.req", i), 32'(bus.imem_req), 32'h1);
            @(negedge clk);
        end
        chk("to.fault", 32'(bus.fault),    32'(FAULT_TIMEOUT));
        chk("to.req",   32'(bus.imem_req), 32'h0);
        chk("to.vld",   32'(bus.ir_valid), 32'h0);

        // Ack coinciding with expiry wins
        async_reset("rst_to");
        repeat (15) @(negedge clk);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hCAFE_0016;
        @(negedge clk);
        idle_inputs();
        chk("ack16.vld",   32'(bus.ir_valid), 32'h1);
        chk("ack16.fault", 32'(bus.fault),    32'h0);
        chk("ack16.ir",    bus.ir,            32'hCAFE_0016);
        bus.ir_ready = 1'b1;
        @(negedge clk);
        bus.ir_ready = 1'b0;
        bus.ex_done  = 1'b1;
        @(negedge clk);
        idle_inputs();
        chk("ack16.pc",  bus.pc,            32'h4);
        chk("ack16.req", 32'(bus.imem_req), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
